bin_to_bcd_4digits: RTL

Sequential binary-to-BCD converter that produces the 4-digit packed BCD operands consumed by `bcd_comparator_4digits` (`a`, `b`). It accepts a 14-bit unsigned binary value on a start pulse and runs a shift-and-add-3 (double-dabble) sequence, one bit per clock. It returns a 16-bit packed BCD result with a one-cycle done pulse. Values above 9999 saturate to 9999 and raise an overflow flag.

---
 rtl/bin_to_bcd_4digits.sv | 89 ++++++++
 1 files changed

// File: rtl/bin_to_bcd_4digits.sv
// Purpose : sequential 14-bit binary to 4-digit packed BCD converter using the
//           shift-and-add-3 (double-dabble) method, one input bit per clock.
//           Inputs above 9999 saturate to 16'h9999 and raise ovf.
// Ports   : clk, reset (sync, active-high), start/bin (request, sampled in IDLE),
//           bcd/ovf (held result), busy (conversion running), done (1-cycle pulse).
// Latency : 14 cycles from the accepted start edge to done; start in SHIFT is ignored.
module bin_to_bcd_4digits (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [13:0] MAX_VAL = 14'd9999;
  localparam logic [15:0] SAT_BCD = 16'h9999;

  state_t      state;
  logic [13:0] bin_sr;       // remaining binary bits, MSB shifts out first
  logic [15:0] work;         // BCD accumulator
  logic [3:0]  cnt;          // iterations remaining after the current one
  logic        ovf_pending;

  logic [15:0] work_adj;     // accumulator after the add-3 correction
  logic [29:0] shifted;      // {work_adj, bin_sr} << 1

  // Add 3 to any digit that would reach 10 or more after doubling.
  function automatic logic [3:0] dabble(input logic [3:0] d);
    dabble = (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  always_comb begin
    work_adj = {dabble(work[15:12]), dabble(work[11:8]),
                dabble(work[7:4]),   dabble(work[3:0])};
    // Bit 29 of the concatenation falls off here; it can only be set for
    // out-of-range inputs, whose result is replaced by the saturation value.
    shifted  = {work_adj, bin_sr} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bin_sr      <= '0;
      work        <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      bcd         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr      <= bin;
            work        <= '0;
            cnt         <= 4'd13;
            ovf_pending <= (bin > MAX_VAL);
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          work   <= shifted[29:14];
          bin_sr <= shifted[13:0];
          cnt    <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            bcd   <= ovf_pending ? SAT_BCD : shifted[29:14];
            ovf   <= ovf_pending;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
